// File: rtl/rnn_param_loader.sv
// ----------------------------------------------------------------------------
// rnn_param_loader
//
// Streams RNN weights and per-inference inputs into a memory-mapped
// accelerator, kicks off an inference, polls its status register, reads the
// Q16 result back and presents it on a valid/ready output.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   load_w              pulse in IDLE: begin a 345-word weight load
//   s_valid/s_ready     input word handshake (s_data, Q16)
//   m_valid/m_ready     result handshake (m_data, Q16)
//   busy                high whenever the controller is not IDLE
//   w_loaded            a complete weight set has been written
//   err                 sticky: status polling timed out
//   bus_write/bus_read  accelerator strobes, at most one per cycle
//   bus_addr/bus_wdata  accelerator register address / write data
//   bus_rdata           accelerator read data, valid the cycle after bus_read
// ----------------------------------------------------------------------------
module rnn_param_loader #(
    parameter int MAX_POLLS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_w,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [15:0] m_data,
    output logic        busy,
    output logic        w_loaded,
    output logic        err,
    output logic        bus_write,
    output logic        bus_read,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata
);

    localparam int                PCNT_W     = $clog2(MAX_POLLS + 1);
    localparam logic [PCNT_W-1:0] POLL_LIMIT = PCNT_W'(MAX_POLLS);
    localparam logic [8:0]        W_LAST     = 9'd344;
    localparam logic [8:0]        I_LAST     = 9'd3;

    typedef enum logic [3:0] {
        IDLE, W_LOAD, I_LOAD, START, POLL_RD, POLL_WAIT,
        RES_RD, RES_WAIT, RELEASE, OUT
    } state_t;

    state_t             r_state, w_state;
    logic [8:0]         r_cnt, w_cnt;
    logic [PCNT_W-1:0]  r_poll, w_poll;
    logic [PCNT_W-1:0]  w_poll_inc;
    logic               r_w_loaded, w_w_loaded;
    logic               r_err, w_err;
    logic               r_bus_write, w_bus_write;
    logic               r_bus_read, w_bus_read;
    logic [31:0]        r_bus_addr, w_bus_addr;
    logic [31:0]        r_bus_wdata, w_bus_wdata;
    logic [15:0]        r_m_data, w_m_data;
    logic               w_accept;
    logic               w_unused_rdata;

    // Register address for weight word n (matrix W, matrix U, bias, FC weights, FC bias)
    function automatic logic [31:0] wload_addr(input logic [8:0] n);
        if (n < 9'd64)       return 32'd2;
        else if (n < 9'd320) return 32'd3;
        else if (n < 9'd328) return 32'd4;
        else if (n < 9'd344) return 32'd5;
        else                 return 32'd6;
    endfunction

    // Upper half of the write word: {row, col} selectors for weight word n.
    // The low 8 bits of n suffice because every region offset is taken mod 256.
    function automatic logic [15:0] wload_sel(input logic [8:0] n);
        logic [7:0] m;
        if (n < 9'd64) begin
            return {4'd0, n[7:4], 4'd0, n[3:0]};
        end else if (n < 9'd320) begin
            m = n[7:0] - 8'd64;
            return {4'd0, m[7:4], 4'd0, m[3:0]};
        end else if (n < 9'd328) begin
            m = n[7:0] - 8'd64;
            return {8'd0, m};
        end else if (n < 9'd344) begin
            m = n[7:0] - 8'd72;
            return {8'd0, m};
        end else begin
            return 16'd0;
        end
    endfunction

    assign s_ready        = (r_state == W_LOAD) || (r_state == I_LOAD);
    assign w_accept       = s_valid && s_ready;
    assign w_poll_inc     = r_poll + 1'b1;
    assign w_unused_rdata = ^bus_rdata[31:16];

    // Bus strobes are registered: the values chosen here appear on the bus
    // in the cycle after the decision, i.e. one cycle after word acceptance.
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_poll      = r_poll;
        w_w_loaded  = r_w_loaded;
        w_err       = r_err;
        w_bus_write = 1'b0;
        w_bus_read  = 1'b0;
        w_bus_addr  = 32'd0;
        w_bus_wdata = 32'd0;
        w_m_data    = r_m_data;

        case (r_state)
            IDLE: begin
                if (load_w) begin
                    w_state    = W_LOAD;
                    w_err      = 1'b0;
                    w_w_loaded = 1'b0;
                    w_cnt      = 9'd0;
                end else if (r_w_loaded && s_valid) begin
                    w_state = I_LOAD;
                    w_cnt   = 9'd0;
                end
            end
            W_LOAD: begin
                if (w_accept) begin
                    w_bus_write = 1'b1;
                    w_bus_addr  = wload_addr(r_cnt);
                    w_bus_wdata = {wload_sel(r_cnt), s_data};
                    if (r_cnt == W_LAST) begin
                        w_w_loaded = 1'b1;
                        w_cnt      = 9'd0;
                        w_state    = IDLE;
                    end else begin
                        w_cnt = r_cnt + 9'd1;
                    end
                end
            end
            I_LOAD: begin
                if (w_accept) begin
                    w_bus_write = 1'b1;
                    w_bus_addr  = 32'd1;
                    w_bus_wdata = {8'd0, 6'd0, r_cnt[1:0], s_data};
                    if (r_cnt == I_LAST) begin
                        w_cnt   = 9'd0;
                        w_state = START;
                    end else begin
                        w_cnt = r_cnt + 9'd1;
                    end
                end
            end
            START: begin
                // First cycle: the last input write is on the bus, queue the
                // start write. Second cycle: start write is on the bus, queue the poll.
                if (r_bus_write && (r_bus_addr == 32'd0)) begin
                    w_bus_read = 1'b1;
                    w_poll     = '0;
                    w_state    = POLL_RD;
                end else begin
                    w_bus_write = 1'b1;
                end
            end
            POLL_RD: begin
                w_state = POLL_WAIT;
            end
            POLL_WAIT: begin
                if (bus_rdata[1:0] == 2'b11) begin
                    w_bus_read = 1'b1;
                    w_bus_addr = 32'd7;
                    w_state    = RES_RD;
                end else if (w_poll_inc == POLL_LIMIT) begin
                    w_poll  = w_poll_inc;
                    w_err   = 1'b1;
                    w_state = IDLE;
                end else begin
                    w_poll     = w_poll_inc;
                    w_bus_read = 1'b1;
                    w_state    = POLL_RD;
                end
            end
            RES_RD: begin
                w_state = RES_WAIT;
            end
            RES_WAIT: begin
                w_m_data    = bus_rdata[15:0];
                w_bus_write = 1'b1;
                w_state     = RELEASE;
            end
            RELEASE: begin
                w_state = OUT;
            end
            OUT: begin
                if (m_ready) w_state = IDLE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= 9'd0;
            r_poll      <= '0;
            r_w_loaded  <= 1'b0;
            r_err       <= 1'b0;
            r_bus_write <= 1'b0;
            r_bus_read  <= 1'b0;
            r_bus_addr  <= 32'd0;
            r_bus_wdata <= 32'd0;
            r_m_data    <= 16'd0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_poll      <= w_poll;
            r_w_loaded  <= w_w_loaded;
            r_err       <= w_err;
            r_bus_write <= w_bus_write;
            r_bus_read  <= w_bus_read;
            r_bus_addr  <= w_bus_addr;
            r_bus_wdata <= w_bus_wdata;
            r_m_data    <= w_m_data;
        end
    end

    assign m_valid   = (r_state == OUT);
    assign busy      = (r_state != IDLE);
    assign m_data    = r_m_data;
    assign w_loaded  = r_w_loaded;
    assign err       = r_err;
    assign bus_write = r_bus_write;
    assign bus_read  = r_bus_read;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_rnn_param_loader.sv
// ----------------------------------------------------------------------------
// tb_rnn_param_loader
//
// Randomized bench with a transaction-level reference model: every expected
// accelerator access is queued from the register map rules before stimulus is
// applied, and one monitor pops and compares each bus strobe. The monitor also
// plays the accelerator, answering status and result reads.
// ----------------------------------------------------------------------------
module tb_rnn_param_loader;

    localparam int MAXP = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_w = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_data = 16'd0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [15:0] m_data;
    logic        busy;
    logic        w_loaded;
    logic        err;
    logic        bus_write;
    logic        bus_read;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = 32'd0;

    rnn_param_loader #(.MAX_POLLS(MAXP)) dut (
        .clk(clk), .rst_n(rst_n), .load_w(load_w),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .busy(busy), .w_loaded(w_loaded), .err(err),
        .bus_write(bus_write), .bus_read(bus_read),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rd;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t        exp_q[$];
    logic [15:0] g_words[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          g_done = 0;
    int          poll_n = 0;
    logic [31:0] g_rdres = 32'd0;
    logic [15:0] exp_result = 16'd0;
    bit          obs_en = 1'b0;
    int          obs_n = 0;
    logic [31:0] obs_a[0:399];
    logic [31:0] obs_d[0:399];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_txn(input bit rd, input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.rd = rd; t.addr = a; t.data = d;
        exp_q.push_back(t);
    endtask

    // Weight register map: region base register, then row/col (or index) selectors.
    task automatic push_wload();
        int a, row, col;
        logic [31:0] d;
        for (int n = 0; n < 345; n++) begin
            if (n < 64)       begin a = 2; row = n / 16;        col = n % 16;        end
            else if (n < 320) begin a = 3; row = (n - 64) / 16; col = (n - 64) % 16; end
            else if (n < 328) begin a = 4; row = 0;             col = n - 320;       end
            else if (n < 344) begin a = 5; row = 0;             col = n - 328;       end
            else              begin a = 6; row = 0;             col = 0;             end
            d = (32'(row) << 24) | (32'(col) << 16) | {16'd0, g_words[n]};
            push_txn(1'b0, 32'(a), d);
        end
    endtask

    // Monitor + accelerator model, sampled on the falling edge.
    txn_t        mon_e;
    logic [31:0] mon_r;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_write || bus_read) begin
                chk("bus_excl", {31'd0, bus_write & bus_read}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_strobe: wr=%b rd=%b addr=%h wdata=%h, expected no bus access",
                             bus_write, bus_read, bus_addr, bus_wdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("bus_kind", {31'd0, bus_read}, {31'd0, mon_e.rd});
                    chk("bus_addr", bus_addr, mon_e.addr);
                    if (bus_write) chk("bus_wdata", bus_wdata, mon_e.data);
                end
                if (obs_en && bus_write && obs_n < 400) begin
                    obs_a[obs_n] = bus_addr;
                    obs_d[obs_n] = bus_wdata;
                    obs_n++;
                end
                if (bus_read) begin
                    if (bus_addr == 32'd0) begin
                        poll_n++;
                        mon_r = $urandom;
                        if (g_done != 0 && poll_n == g_done) mon_r[1:0] = 2'b11;
                        else mon_r[1:0] = 2'($urandom_range(0, 2));
                        bus_rdata = mon_r;
                    end else begin
                        bus_rdata = g_rdres;
                    end
                end
            end
            if (m_valid) chk("m_data", {16'd0, m_data}, {16'd0, exp_result});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero();
        chk("rst_s_ready",   {31'd0, s_ready},   32'd0);
        chk("rst_m_valid",   {31'd0, m_valid},   32'd0);
        chk("rst_m_data",    {16'd0, m_data},    32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_w_loaded",  {31'd0, w_loaded},  32'd0);
        chk("rst_err",       {31'd0, err},       32'd0);
        chk("rst_bus_write", {31'd0, bus_write}, 32'd0);
        chk("rst_bus_read",  {31'd0, bus_read},  32'd0);
        chk("rst_bus_addr",  bus_addr,           32'd0);
        chk("rst_bus_wdata", bus_wdata,          32'd0);
    endtask

    // mode 0: s_valid always high; 1: every other cycle; 2: random gaps.
    task automatic stream(input int mode, input int nmax);
        int i, cyc;
        bit v, acc;
        logic [15:0] wd;
        i = 0; cyc = 0;
        while (i < nmax && cyc < 4 * nmax + 20) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
            wd = g_words[i];
            s_valid = v;
            s_data  = v ? wd : 16'($urandom);
            acc = v && s_ready;
            tick();
            if (acc) begin
                chk("wr_next", {15'd0, bus_write, bus_wdata[15:0]}, {15'd0, 1'b1, wd});
                i++;
            end else begin
                chk("wr_hold", {31'd0, bus_write}, 32'd0);
            end
            cyc++;
        end
        s_valid = 1'b0;
        chk("stream_done", i, nmax);
    endtask

    task automatic start_wload(input bit ramp);
        g_words.delete();
        for (int n = 0; n < 345; n++) g_words.push_back(ramp ? 16'(n) : 16'($urandom));
        push_wload();
        load_w = 1'b1;
        tick();
        load_w = 1'b0;
        chk("wl_busy", {31'd0, busy}, 32'd1);
        chk("wl_w_loaded_clr", {31'd0, w_loaded}, 32'd0);
        chk("wl_err_clr", {31'd0, err}, 32'd0);
    endtask

    task automatic finish_wload();
        repeat (3) tick();
        chk("wl_q_empty", exp_q.size(), 32'd0);
        chk("wl_w_loaded", {31'd0, w_loaded}, 32'd1);
        chk("wl_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic idle_svalid();
        for (int c = 0; c < 5; c++) begin
            s_valid = 1'b1;
            s_data  = 16'($urandom);
            tick();
            chk("nl_s_ready", {31'd0, s_ready}, 32'd0);
            chk("nl_busy", {31'd0, busy}, 32'd0);
        end
        s_valid = 1'b0;
    endtask

    // done_poll = 0 or > MAXP means status never reports done.
    task automatic run_inf(input logic [15:0] x0, input logic [15:0] x1, input logic [15:0] x2,
                           input logic [15:0] x3, input int done_poll, input logic [31:0] res_word,
                           input int hold, input int mode, input bit err_before);
        bit tmo, ok;
        int npoll;
        logic [15:0] xs[4];
        tmo = (done_poll == 0) || (done_poll > MAXP);
        xs[0] = x0; xs[1] = x1; xs[2] = x2; xs[3] = x3;
        g_words.delete();
        for (int k = 0; k < 4; k++) begin
            g_words.push_back(xs[k]);
            push_txn(1'b0, 32'd1, {8'd0, 8'(k), xs[k]});
        end
        push_txn(1'b0, 32'd0, 32'd0);
        npoll = tmo ? MAXP : done_poll;
        for (int p = 0; p < npoll; p++) push_txn(1'b1, 32'd0, 32'd0);
        if (!tmo) begin
            push_txn(1'b1, 32'd7, 32'd0);
            push_txn(1'b0, 32'd0, 32'd0);
        end
        g_done = done_poll; g_rdres = res_word; poll_n = 0; exp_result = res_word[15:0];
        stream(mode, 4);
        ok = 1'b0;
        if (tmo) begin
            for (int c = 0; c < 200; c++) begin
                if (!busy) begin ok = 1'b1; break; end
                tick();
            end
            chk("tmo_idle", {31'd0, ok}, 32'd1);
            chk("tmo_err", {31'd0, err}, 32'd1);
            chk("tmo_m_valid", {31'd0, m_valid}, 32'd0);
            chk("tmo_polls", poll_n, MAXP);
        end else begin
            for (int c = 0; c < 200; c++) begin
                if (m_valid) begin ok = 1'b1; break; end
                tick();
            end
            chk("inf_m_valid_seen", {31'd0, ok}, 32'd1);
            for (int c = 0; c < hold; c++) begin
                load_w = (c == 2);
                chk("inf_hold_valid", {31'd0, m_valid}, 32'd1);
                chk("inf_hold_data", {16'd0, m_data}, {16'd0, res_word[15:0]});
                tick();
            end
            load_w = 1'b0;
            m_ready = 1'b1;
            tick();
            m_ready = 1'b0;
            chk("inf_m_valid_drop", {31'd0, m_valid}, 32'd0);
            chk("inf_idle", {31'd0, busy}, 32'd0);
            chk("inf_w_loaded", {31'd0, w_loaded}, 32'd1);
            chk("inf_err", {31'd0, err}, {31'd0, err_before});
            chk("inf_polls", poll_n, done_poll);
        end
        repeat (4) tick();
        chk("inf_q_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) tick();
        check_zero();
        rst_n = 1'b1;
        tick();
        check_zero();

        // Inputs before any weight load are ignored
        idle_svalid();

        // Partial load aborted by reset at word 100
        start_wload(1'b0);
        stream(1, 100);
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        check_zero();
        tick();
        rst_n = 1'b1;
        tick();
        check_zero();
        idle_svalid();

        // Full ramp load, pinned against hand-computed register writes
        obs_n = 0;
        obs_en = 1'b1;
        start_wload(1'b1);
        stream(0, 345);
        finish_wload();
        obs_en = 1'b0;
        chk("lit_nwrites", obs_n, 345);
        chk("lit_a0",   obs_a[0],   32'd2);
        chk("lit_d0",   obs_d[0],   32'h0000_0000);
        chk("lit_a63",  obs_a[63],  32'd2);
        chk("lit_d63",  obs_d[63],  32'h030F_003F);
        chk("lit_a64",  obs_a[64],  32'd3);
        chk("lit_d64",  obs_d[64],  32'h0000_0040);
        chk("lit_a344", obs_a[344], 32'd6);
        chk("lit_d344", obs_d[344], 32'h0000_0158);

        // Inference: done on 3rd poll, result held 10 cycles
        run_inf(16'h1000, 16'h2000, 16'h3000, 16'h4000, 3, 32'h0000_ABCD, 10, 0, 1'b0);

        // Timeout: status never done
        run_inf(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 0, 32'd0, 0, 2, 1'b1);

        // Done on the last permitted poll; err stays sticky
        run_inf(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), MAXP,
                $urandom, 3, 2, 1'b1);

        // Backpressured random load clears err
        start_wload(1'b0);
        stream(1, 345);
        finish_wload();
        chk("reload_err", {31'd0, err}, 32'd0);

        // Randomized inferences
        for (int r = 0; r < 4; r++) begin
            run_inf(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                    $urandom_range(1, MAXP), $urandom, $urandom_range(0, 5), 2, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rnn_param_loader.md
RNN_PARAM_LOADER -- requirements
Module: rnn_param_loader

Interface
REQ-001 SHALL have parameter MAX_POLLS, default 1024: status polls allowed per inference before timeout.
REQ-002 SHALL have ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- load_w  in  1  pulse; start weight load
- s_valid  in  1  parameter/input word valid
- s_ready  out  1  word accepted when s_valid & s_ready
- s_data  in  16  Q16 word
- m_valid  out  1  result valid
- m_ready  in  1  result accepted
- m_data  out  16  Q16 result
- busy  out  1  high in any state except IDLE
- w_loaded  out  1  full weight set written
- err  out  1  sticky poll timeout
- bus_write  out  1  accelerator write strobe
- bus_read  out  1  accelerator read strobe
- bus_addr  out  32  accelerator register address
- bus_wdata  out  32  accelerator write data
- bus_rdata  in  32  accelerator read data, valid the cycle after bus_read

Function
REQ-003 SHALL implement states IDLE, W_LOAD, I_LOAD, START, POLL_RD, POLL_WAIT, RES_RD, RES_WAIT, RELEASE, OUT.
REQ-004 IDLE: load_w -> W_LOAD (clears err, w_loaded, word count); else w_loaded & s_valid -> I_LOAD; load_w has priority; load_w is ignored outside IDLE.
REQ-005 s_ready SHALL be high only in W_LOAD and I_LOAD; throughput one word per cycle.
REQ-006 Each accepted word SHALL produce exactly one single-cycle bus_write on the next cycle, with bus_wdata[15:0] = word.
REQ-007 W_LOAD: 345 words, 9-bit count n:
- n 0-63: addr 2, wdata[31:24]=n[7:4] row, [23:16]=n[3:0] col.
- n 64-319: addr 3, m=n-64, row=m[7:4], col=m[3:0].
- n 320-327: addr 4, [23:16]=n-320.
- n 328-343: addr 5, [23:16]=n-328.
- n 344: addr 6, [31:16]=0.
Unused wdata fields are 0.
REQ-008 After word 344 is accepted: w_loaded=1 and -> IDLE.
REQ-009 I_LOAD: 4 words, index k 0-3; addr 1, [23:16]=k. After the 4th is accepted -> START.
REQ-010 START: SHALL wait for the last input write to issue, then issue one write to addr 0 with wdata 0, then -> POLL_RD.
REQ-011 POLL_RD: bus_read=1 at addr 0 for one cycle; -> POLL_WAIT.
REQ-012 POLL_WAIT: sample bus_rdata[1:0]. If 2'b11 (done) -> RES_RD. Else poll count+1; if count reaches MAX_POLLS, set err=1 and -> IDLE with no release write; otherwise -> POLL_RD.
REQ-013 RES_RD: read addr 7; RES_WAIT: capture bus_rdata[15:0] into m_data; -> RELEASE.
REQ-014 RELEASE: one write to addr 0, wdata 0; -> OUT.
REQ-015 OUT: m_valid=1 until m_ready is sampled high, then -> IDLE; m_data SHALL stay stable while m_valid is high.
REQ-016 bus_write and bus_read SHALL never be high in the same cycle; at most one bus strobe per cycle.
REQ-017 Poll count SHALL clear on entry to POLL_RD from START.
REQ-018 If s_valid drops mid-load, the FSM SHALL hold its state and count with no bus activity.

Reset
REQ-019 On rst_n low, the SHALL take state=IDLE and all outputs and counters 0: s_ready, m_valid, m_data, busy, w_loaded, err, bus_write, bus_read, bus_addr, bus_wdata.
REQ-020 Reset mid-load SHALL discard partial progress; w_loaded=0 after reset.

Verification
REQ-021 Weight load: load_w, then stream 345 words 0x0000-0x0158 -> write 0 addr 2 wdata 0x00000000; write 63 addr 2 wdata 0x030F003F; write 64 addr 3 wdata 0x00000040; write 344 addr 6 wdata 0x00000158; w_loaded=1.
REQ-022 Inference: inputs 0x1000,0x2000,0x3000,0x4000, done reported on 3rd poll, addr 7 reads 0x0000ABCD -> addr 1 writes with sel 0-3, one start write, 3 reads, release write, m_data=0xABCD, m_valid held until m_ready.
REQ-023 Timeout: MAX_POLLS=4, status never 3 -> exactly 4 polls, err=1, IDLE, no release write.
REQ-024 Backpressure: s_valid toggled every other cycle during W_LOAD -> same 345 writes in same order; m_ready held low 10 cycles -> m_valid held, m_data stable.
REQ-025 Reset asserted at word 100 of W_LOAD -> all outputs 0, w_loaded=0; s_valid before load_w -> no input accepted.
